restoring_divider: RTL and testbench



---
 rtl/restoring_divider.sv | 112 +++++++++++
 tb/tb_restoring_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock behind a start/done handshake.
// A zero divisor takes a single pass through RUN and returns an all-ones
// quotient, the low dividend byte as remainder, and the div_by_zero flag.
module restoring_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [N:0]       r;        // partial remainder
  logic [2*N-1:0]   q;        // dividend shifted out, quotient shifted in
  logic [N-1:0]     d;        // latched divisor
  logic [CNT_W-1:0] cnt;
  logic             zero_div; // latched "divisor was zero" for the short pass

  logic [N:0]       shifted;
  logic [N:0]       trial;
  logic             borrow;
  logic             accept;
  logic             last_iter;

  // Trial subtraction of the divisor from the shifted partial remainder.
  // Since r < d before the shift, a non-negative difference always fits in
  // N bits, so the MSB of the N+1-bit result is exactly the borrow.
  assign shifted   = {r[N-1:0], q[2*N-1]};
  assign trial     = shifted - {1'b0, d};
  assign borrow    = trial[N];
  assign accept    = (state == S_IDLE) && start;
  assign last_iter = (cnt == CNT_LAST);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always lasts exactly one cycle and ignores start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (zero_div || last_iter) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Working datapath: loaded on acceptance, one shift-subtract step per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      q        <= dividend;
      r        <= '0;
      d        <= divisor;
      zero_div <= (divisor == '0);
    end else if (state == S_RUN) begin
      if (!borrow) begin
        r <= trial;
        q <= {q[2*N-2:0], 1'b1};
      end else begin
        r <= shifted;
        q <= {q[2*N-2:0], 1'b0};
      end
    end
  end

  // Iteration counter and result registers; results change only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= q[N-1:0];
        div_by_zero <= 1'b1;
      end else if (last_iter) begin
        quotient    <= {q[2*N-2:0], ~borrow};
        remainder   <= borrow ? shifted[N-1:0] : trial[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (N=8): directed vector table,
// back-to-back held start, reset abort, ignored mid-run start, random pairs.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  restoring_divider #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at #1 after an edge while idle. Returns results and the number of
  // edges from the accepting edge to done being visible (-1 on timeout).
  task automatic run_div(input logic [15:0] dd, input logic [7:0] dv,
                         output logic [15:0] qo, output logic [7:0] ro,
                         output logic zo, output int lat);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    qo = quotient; ro = remainder; zo = div_by_zero;
    if (lat > 0) begin
      chk("busy_in_done", busy, 1);
      @(posedge clk); #1;
      chk("busy_idle_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  vec_t vecs[13];
  vec_t bb[5];

  initial begin
    logic [15:0] qo;
    logic [7:0]  ro;
    logic        zo;
    int          lat;
    int          last_cyc;
    int          ndone;
    logic        got;

    vecs[0]  = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0, 16};
    vecs[1]  = '{16'd300,   8'd25,  16'd12,    8'd0,   1'b0, 16};
    vecs[2]  = '{16'd2601,  8'd13,  16'd200,   8'd1,   1'b0, 16};
    vecs[3]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
    vecs[4]  = '{16'd7,     8'd200, 16'd0,     8'd7,   1'b0, 16};
    vecs[5]  = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0, 16};
    vecs[6]  = '{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 1};
    vecs[7]  = '{16'd100,   8'd7,   16'd14,    8'd2,   1'b0, 16};
    vecs[8]  = '{16'd50000, 8'd3,   16'd16666, 8'd2,   1'b0, 16};
    vecs[9]  = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
    vecs[10] = '{16'd65535, 8'd254, 16'd258,   8'd3,   1'b0, 16};
    vecs[11] = '{16'd255,   8'd0,   16'hFFFF,  8'hFF,  1'b1, 1};
    vecs[12] = '{16'd1000,  8'd10,  16'd100,   8'd0,   1'b0, 16};

    bb[0] = '{16'd300,   8'd25,  16'd12,    8'd0, 1'b0, 16};
    bb[1] = '{16'd2601,  8'd13,  16'd200,   8'd1, 1'b0, 16};
    bb[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 16};
    bb[3] = '{16'd7,     8'd200, 16'd0,     8'd7, 1'b0, 16};
    bb[4] = '{16'd0,     8'd9,   16'd0,     8'd0, 1'b0, 16};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, qo, ro, zo, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_quotient", i), qo, vecs[i].eq);
      chk($sformatf("vec%0d_remainder", i), ro, vecs[i].er);
      chk($sformatf("vec%0d_dbz", i), zo, vecs[i].ez);
    end

    // Back-to-back with start held high; operands for the next division are
    // presented during the done cycle, before the next accepting edge.
    start = 1'b1; dividend = bb[0].dd; divisor = bb[0].dv;
    last_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      got = 1'b0;
      for (int j = 0; j < 40; j++) begin
        @(posedge clk); #1;
        if (done) begin got = 1'b1; break; end
      end
      chk($sformatf("b2b%0d_done_seen", i), got, 1);
      chk($sformatf("b2b%0d_quotient", i), quotient, bb[i].eq);
      chk($sformatf("b2b%0d_remainder", i), remainder, bb[i].er);
      if (i > 0) chk($sformatf("b2b%0d_gap", i), cyc - last_cyc, 18);
      last_cyc = cyc;
      if (i < 4) begin
        dividend = bb[i+1].dd; divisor = bb[i+1].dv;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("b2b_idle", busy, 0);

    // Reset abort at iteration 8.
    start = 1'b1; dividend = 16'd50000; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    ndone = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_div(16'd50000, 8'd3, qo, ro, zo, lat);
    chk("abort_rerun_quotient", qo, 16666);
    chk("abort_rerun_remainder", ro, 2);

    // Second start mid-run must be ignored.
    start = 1'b1; dividend = 16'd1000; divisor = 8'd10;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd100; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    got = 1'b1;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        ndone++;
        chk("midstart_quotient", quotient, 100);
        chk("midstart_remainder", remainder, 0);
        chk("midstart_busy_in_done", busy, 1);
        @(posedge clk); #1;
        chk("midstart_idle_after", busy, 0);
        break;
      end
      if (!busy) got = 1'b0;
      @(posedge clk); #1;
    end
    chk("midstart_busy_held", got, 1);
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midstart_single_done", ndone, 1);

    // Randomised pairs, alternating plain random and products a*b.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] dd;
      logic [7:0]  dv;
      logic [7:0]  b;
      if (i % 2 == 0) begin
        dd = 16'($urandom_range(0, 65535));
        dv = 8'($urandom_range(1, 255));
        b  = '0;
      end else begin
        dv = 8'($urandom_range(1, 255));
        b  = 8'($urandom_range(0, 255));
        dd = 16'(dv * b);
      end
      run_div(dd, dv, qo, ro, zo, lat);
      if (lat != 16 || qo * dv + ro != dd || ro >= dv || zo !== 1'b0)
        chk($sformatf("rand%0d_%0d/%0d_invariant", i, dd, dv), 0, 1);
      else
        chk("rand_invariant", 1, 1);
      if (i % 2 == 1) begin
        chk($sformatf("rand%0d_product_quotient", i), qo, b);
        chk($sformatf("rand%0d_product_remainder", i), ro, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
